// File: rtl/alu_issue_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage_pkg
//  Purpose  : Shared constants and ALU operation encodings for the ALU issue
//             stage and its forwarding mux.
//  Contents : XLEN, REG_AW, alu_ctrl_e, is_x0()
//  Revision : 1.0  initial release
// ============================================================================
package alu_issue_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  // x0 is hardwired to zero and is never a real forwarding target.
  function automatic logic is_x0(input logic [REG_AW-1:0] addr);
    return addr == '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_stage_operand_forward_mux.sv
`default_nettype none
// ============================================================================
//  Module   : operand_forward_mux
//  Purpose  : Combinational operand bypass selection for one source register.
//  Ports    : addr_i        source register index
//             rf_data_i     register-file read data
//             exm_wen_i/exm_rd_i/exm_data_i/exm_is_load_i  EX/MEM source
//             wb_wen_i/wb_rd_i/wb_data_i                   MEM/WB source
//             data_o        forwarded operand value
//  Revision : 1.0  initial release
// ============================================================================
module operand_forward_mux
  import alu_issue_stage_pkg::*;
(
  input  logic [REG_AW-1:0] addr_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic              exm_wen_i,
  input  logic [REG_AW-1:0] exm_rd_i,
  input  logic [XLEN-1:0]   exm_data_i,
  input  logic              exm_is_load_i,
  input  logic              wb_wen_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic [XLEN-1:0]   data_o
);

  // A load in EX/MEM has no data yet; it is never a bypass source here.
  // The issue stage stalls on that case instead.
  always_comb begin
    data_o = rf_data_i;
    if (is_x0(addr_i)) begin
      data_o = '0;
    end else if (exm_wen_i && (exm_rd_i == addr_i) && !exm_is_load_i) begin
      data_o = exm_data_i;
    end else if (wb_wen_i && (wb_rd_i == addr_i)) begin
      data_o = wb_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : Single-entry operand pipeline register between decode and the
//             ALU, with operand forwarding, load-use stall and flush.
//  Ports    : clk, reset                  clock, sync active-high reset
//             in_valid/in_ready           decode handshake
//             in_rs1/rs2_addr, _data      source indices and RF data
//             in_imm, in_use_imm          immediate and op2 select
//             in_alu_ctrl, in_rd          operation and destination
//             exm_*, wb_*                 forwarding sources
//             flush                       kill held and incoming instruction
//             out_valid/out_ready         execute handshake
//             out_op1/op2/alu_ctrl/rd     registered payload
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REG_AW-1:0]   in_rs1_addr,
  input  logic [REG_AW-1:0]   in_rs2_addr,
  input  logic [XLEN-1:0]     in_rs1_data,
  input  logic [XLEN-1:0]     in_rs2_data,
  input  logic [XLEN-1:0]     in_imm,
  input  logic                in_use_imm,
  input  logic [3:0]          in_alu_ctrl,
  input  logic [REG_AW-1:0]   in_rd,
  input  logic                exm_wen,
  input  logic [REG_AW-1:0]   exm_rd,
  input  logic [XLEN-1:0]     exm_data,
  input  logic                exm_is_load,
  input  logic                wb_wen,
  input  logic [REG_AW-1:0]   wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_op1,
  output logic [XLEN-1:0]     out_op2,
  output logic [3:0]          out_alu_ctrl,
  output logic [REG_AW-1:0]   out_rd
);

  logic [XLEN-1:0]   fwd_rs1_w;
  logic [XLEN-1:0]   fwd_rs2_w;
  logic              stall_w;
  logic              accept_w;

  logic              valid_q,    valid_d;
  logic [XLEN-1:0]   op1_q,      op1_d;
  logic [XLEN-1:0]   op2_q,      op2_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic [REG_AW-1:0] rd_q,       rd_d;

  operand_forward_mux u_fwd_rs1 (
    .addr_i        (in_rs1_addr),
    .rf_data_i     (in_rs1_data),
    .exm_wen_i     (exm_wen),
    .exm_rd_i      (exm_rd),
    .exm_data_i    (exm_data),
    .exm_is_load_i (exm_is_load),
    .wb_wen_i      (wb_wen),
    .wb_rd_i       (wb_rd),
    .wb_data_i     (wb_data),
    .data_o        (fwd_rs1_w)
  );

  operand_forward_mux u_fwd_rs2 (
    .addr_i        (in_rs2_addr),
    .rf_data_i     (in_rs2_data),
    .exm_wen_i     (exm_wen),
    .exm_rd_i      (exm_rd),
    .exm_data_i    (exm_data),
    .exm_is_load_i (exm_is_load),
    .wb_wen_i      (wb_wen),
    .wb_rd_i       (wb_rd),
    .wb_data_i     (wb_data),
    .data_o        (fwd_rs2_w)
  );

  // Load-use hazard: the load result is not available until it reaches WB.
  // rs2 only matters when op2 actually comes from the register file.
  assign stall_w = in_valid && exm_wen && exm_is_load && !is_x0(exm_rd) &&
                   ((exm_rd == in_rs1_addr) ||
                    (!in_use_imm && (exm_rd == in_rs2_addr)));

  assign in_ready = (!valid_q || out_ready) && !stall_w && !flush;
  assign accept_w = in_valid && in_ready;

  always_comb begin
    valid_d    = valid_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    alu_ctrl_d = alu_ctrl_q;
    rd_d       = rd_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_w) begin
      valid_d    = 1'b1;
      op1_d      = fwd_rs1_w;
      op2_d      = in_use_imm ? in_imm : fwd_rs2_w;
      alu_ctrl_d = in_alu_ctrl;
      rd_d       = in_rd;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      alu_ctrl_q <= ALU_ADD;
      rd_q       <= '0;
    end else begin
      valid_q    <= valid_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      alu_ctrl_q <= alu_ctrl_d;
      rd_q       <= rd_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_op1      = op1_q;
  assign out_op2      = op2_q;
  assign out_alu_ctrl = alu_ctrl_q;
  assign out_rd       = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Self-checking bench for alu_issue_stage: behavioural model with
//             per-cycle comparison plus directed vectors with literal values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm;
  logic [3:0]  in_alu_ctrl;
  logic [4:0]  in_rd;
  logic        exm_wen;
  logic [4:0]  exm_rd;
  logic [31:0] exm_data;
  logic        exm_is_load;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2;
  logic [3:0]  out_alu_ctrl;
  logic [4:0]  out_rd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_alu_ctrl(in_alu_ctrl), .in_rd(in_rd),
    .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
    .exm_is_load(exm_is_load),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2),
    .out_alu_ctrl(out_alu_ctrl), .out_rd(out_rd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid;
  logic [31:0] m_op1, m_op2;
  logic [3:0]  m_ctrl;
  logic [4:0]  m_rd;
  logic        m_live = 1'b0;

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 32'h0;
    if (exm_wen && exm_rd == a && !exm_is_load) return exm_data;
    if (wb_wen && wb_rd == a) return wb_data;
    return rf;
  endfunction

  function automatic logic m_ready();
    logic hazard;
    hazard = in_valid && exm_wen && exm_is_load && exm_rd != 0 &&
             (exm_rd == in_rs1_addr || (!in_use_imm && exm_rd == in_rs2_addr));
    return (!m_valid || out_ready) && !hazard && !flush;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 0; m_op1 = 0; m_op2 = 0; m_ctrl = 0; m_rd = 0;
      m_live  = 1;
    end else if (m_live) begin
      if (flush) m_valid = 0;
      else if (in_valid && m_ready()) begin
        m_valid = 1;
        m_op1   = fwd(in_rs1_addr, in_rs1_data);
        m_op2   = in_use_imm ? in_imm : fwd(in_rs2_addr, in_rs2_data);
        m_ctrl  = in_alu_ctrl;
        m_rd    = in_rd;
      end else if (out_ready) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_valid",    {31'b0, out_valid}, {31'b0, m_valid});
      chk("model_op1",      out_op1, m_op1);
      chk("model_op2",      out_op2, m_op2);
      chk("model_ctrl",     {28'b0, out_alu_ctrl}, {28'b0, m_ctrl});
      chk("model_rd",       {27'b0, out_rd}, {27'b0, m_rd});
      chk("model_in_ready", {31'b0, in_ready}, {31'b0, m_ready()});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_use_imm = 0;
    in_alu_ctrl = 0; in_rd = 0; exm_wen = 0; exm_rd = 0; exm_data = 0;
    exm_is_load = 0; wb_wen = 0; wb_rd = 0; wb_data = 0; flush = 0;
    out_ready = 1;
    cyc(); cyc();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_op1", out_op1, 32'h0);
    chk("rst_op2", out_op2, 32'h0);
    chk("rst_ctrl", {28'b0, out_alu_ctrl}, 32'd0);
    chk("rst_rd", {27'b0, out_rd}, 32'd0);
    reset = 0; #1;
    chk("ready_after_reset", {31'b0, in_ready}, 32'd1);

    // forwarding priority: EX/MEM beats MEM/WB
    in_valid = 1; in_rs1_addr = 5; in_rs1_data = 32'h55; in_use_imm = 1;
    in_imm = 32'h100; in_alu_ctrl = 4'b0001; in_rd = 3;
    exm_wen = 1; exm_rd = 5; exm_data = 32'h11;
    wb_wen = 1; wb_rd = 5; wb_data = 32'h22;
    cyc();
    chk("fwd_exm_op1", out_op1, 32'h11);
    chk("fwd_imm_op2", out_op2, 32'h100);
    chk("fwd_valid", {31'b0, out_valid}, 32'd1);
    chk("fwd_ctrl", {28'b0, out_alu_ctrl}, 32'd1);
    exm_wen = 0;
    cyc();
    chk("fwd_wb_op1", out_op1, 32'h22);

    // x0 always reads zero
    in_rs1_addr = 0; in_rs1_data = 32'hFFFF_FFFF; exm_wen = 1; exm_rd = 0;
    wb_wen = 0;
    cyc();
    chk("x0_op1", out_op1, 32'h0);

    // load-use stall on rs2
    exm_wen = 1; exm_is_load = 1; exm_rd = 7; exm_data = 32'hDEAD;
    in_rs1_addr = 1; in_rs1_data = 32'h1; in_rs2_addr = 7; in_rs2_data = 32'h99;
    in_use_imm = 0; in_rd = 4;
    #1;
    chk("loaduse_ready", {31'b0, in_ready}, 32'd0);
    cyc();
    chk("loaduse_bubble", {31'b0, out_valid}, 32'd0);
    exm_wen = 0; wb_wen = 1; wb_rd = 7; wb_data = 32'hAB;
    #1;
    chk("loaduse_release", {31'b0, in_ready}, 32'd1);
    cyc();
    chk("loaduse_op2", out_op2, 32'hAB);
    exm_wen = 1; in_use_imm = 1; in_imm = 32'h7;
    #1;
    chk("loaduse_imm_nostall", {31'b0, in_ready}, 32'd1);

    // backpressure
    exm_wen = 0; exm_is_load = 0; wb_wen = 0;
    in_rs1_addr = 2; in_rs1_data = 32'h1234;
    cyc();
    chk("bp_first_op1", out_op1, 32'h1234);
    out_ready = 0; in_rs1_data = 32'h5678; in_alu_ctrl = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", {31'b0, in_ready}, 32'd0);
      cyc();
      chk("bp_hold_op1", out_op1, 32'h1234);
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    cyc();
    chk("bp_next_op1", out_op1, 32'h5678);

    // flush with a held entry and an incoming instruction
    flush = 1; in_rs1_data = 32'h9999;
    #1;
    chk("flush_ready", {31'b0, in_ready}, 32'd0);
    cyc();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_drop_op1", out_op1, 32'h5678);
    flush = 0; in_valid = 0;
    cyc();

    // reset with a held entry
    in_valid = 1; in_rs1_data = 32'hCAFE; in_alu_ctrl = 4'b0100; in_rd = 9;
    out_ready = 0;
    cyc();
    chk("pre_reset_valid", {31'b0, out_valid}, 32'd1);
    reset = 1; flush = 1;
    cyc();
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_op1", out_op1, 32'h0);
    chk("reset_op2", out_op2, 32'h0);
    chk("reset_ctrl", {28'b0, out_alu_ctrl}, 32'd0);
    chk("reset_rd", {27'b0, out_rd}, 32'd0);
    reset = 0; flush = 0;

    // short mixed sequence, checked by the model only
    for (int i = 0; i < 24; i++) begin
      in_valid    = (i % 3) != 2;
      out_ready   = (i % 4) != 1;
      in_rs1_addr = 5'(i % 8);
      in_rs2_addr = 5'((i + 3) % 8);
      in_rs1_data = 32'h1000 + i;
      in_rs2_data = 32'h2000 + i;
      in_imm      = 32'h3000 + i;
      in_use_imm  = (i % 5) == 0;
      in_alu_ctrl = 4'(i % 10);
      in_rd       = 5'(i);
      exm_wen     = (i % 2) == 0;
      exm_rd      = 5'((i + 1) % 8);
      exm_data    = 32'h4000 + i;
      exm_is_load = (i % 6) == 0;
      wb_wen      = 1;
      wb_rd       = 5'((i + 2) % 8);
      wb_data     = 32'h5000 + i;
      flush       = (i % 11) == 10;
      cyc();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Clock and reset: one clock, synchronous active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset, sampled on rising clk.
REQ-004 in_valid  in  1  decode presents an instruction.
REQ-005 in_ready  out  1  stage accepts the instruction this cycle.
REQ-006 in_rs1_addr, in_rs2_addr  in  5 each  source register indices.
REQ-007 in_rs1_data, in_rs2_data  in  32 each  register-file read data.
REQ-008 in_imm  in  32  sign-extended immediate.
REQ-009 in_use_imm  in  1  op2 is taken from in_imm; rs2 is unused.
REQ-010 in_alu_ctrl  in  4  ALU operation code.
REQ-011 in_rd  in  5  destination register index.
REQ-012 exm_wen, exm_rd, exm_data, exm_is_load  in  1/5/32/1  EX/MEM forwarding source.
REQ-013 wb_wen, wb_rd, wb_data  in  1/5/32  MEM/WB forwarding source.
REQ-014 flush  in  1  kill the held and incoming instruction (branch redirect).
REQ-015 out_valid  out  1  registered operands are valid for the ALU.
REQ-016 out_ready  in  1  execute consumes the held entry.
REQ-017 out_op1, out_op2  out  32 each  registered ALU operands.
REQ-018 out_alu_ctrl  out  4  registered ALU operation code.
REQ-019 out_rd  out  5  registered destination index.

Function
REQ-020 The stage SHALL be a single-entry pipeline register with 1-cycle latency: an instruction accepted at edge N appears on the outputs after edge N.
REQ-021 Acceptance SHALL occur on the edge where in_valid & in_ready.
REQ-022 in_ready SHALL equal (~out_valid | out_ready) & ~stall & ~flush, where stall is the load-use stall defined in REQ-026.
REQ-023 Operand forwarding SHALL follow this priority for each source rsX:
- addr==0 -> 0
- else exm_wen & exm_rd==addr & ~exm_is_load -> exm_data
- else wb_wen & wb_rd==addr -> wb_data
- else register-file data.
REQ-024 out_op1 SHALL be the forwarded rs1 value.
REQ-025 out_op2 SHALL be in_imm when in_use_imm is set, otherwise the forwarded rs2 value.
REQ-026 stall SHALL equal in_valid & exm_wen & exm_is_load & exm_rd!=0 & (exm_rd==in_rs1_addr | (~in_use_imm & exm_rd==in_rs2_addr)). stall SHALL hold for as long as the condition is true; during stall no capture occurs.
REQ-027 When out_ready is set and no new acceptance occurs, out_valid SHALL clear on the next edge, which inserts a bubble.
REQ-028 While out_valid & ~out_ready, out_op1, out_op2, out_alu_ctrl and out_rd SHALL hold stable.
REQ-029 flush SHALL clear out_valid on the next edge and suppress capture. flush has priority over acceptance, hold and stall.
REQ-030 out_op1, out_op2, out_alu_ctrl and out_rd SHALL update only on acceptance. Payload registers SHALL not change while out_valid is 0 without an acceptance.
REQ-031 All datapath widths SHALL be 32 bits. There is no arithmetic in this stage.

Reset
REQ-032 On reset, out_valid SHALL be 0, out_op1 and out_op2 SHALL be 32'h0, out_alu_ctrl SHALL be 4'b0000 (ADD), and out_rd SHALL be 0.
REQ-033 Reset mid-operation SHALL discard the held entry, and reset SHALL take priority over flush and acceptance.
REQ-034 in_ready SHALL be 1 in the first cycle after reset is deasserted, provided no stall or flush is present.

Structure
REQ-035 A shared package SHALL hold the XLEN=32 constant and the ALU control encodings:
- ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100
- SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
REQ-036 Forwarding selection SHALL be a combinational sub-module, operand_forward_mux, instantiated twice (rs1 and rs2).
REQ-037 The stall and handshake logic and the pipeline register SHALL reside in alu_issue_stage.

Verification
REQ-038 Forward priority: rs1=5 with exm_wen, exm_rd=5, exm_data=0x11, and wb_rd=5, wb_data=0x22 -> out_op1=0x11. With exm_wen=0 -> out_op1=0x22.
REQ-039 x0: rs1=0, rs1_data=0xFFFFFFFF, exm_rd=0, exm_wen=1 -> out_op1=0.
REQ-040 Load-use: exm_is_load=1, exm_rd=7, in_rs2=7, in_use_imm=0 -> in_ready=0 for 1 cycle. Once exm_wen drops and wb_rd=7, wb_data=0xAB -> accept, out_op2=0xAB. With in_use_imm=1 -> no stall.
REQ-041 Backpressure: out_ready=0 for 3 cycles while holding op1=0x1234 -> outputs stable and in_ready=0. Raising out_ready -> next instruction captured on the following edge.
REQ-042 Flush: flush asserted together with in_valid=1 and out_valid=1 -> out_valid=0 next cycle and the incoming instruction is dropped.
REQ-043 Reset: reset asserted with out_valid=1 -> next cycle out_valid=0, out_op1=0, out_op2=0, out_alu_ctrl=0000, out_rd=0.
